// File: rtl/proc_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package proc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_RUN  = 3'd5,
        ST_ERR  = 3'd6
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         LEN_BYTES = 2;
    localparam int         LEN_W     = 8 * LEN_BYTES;

endpackage

// File: rtl/word_packer.sv
// Assembles four little-endian stream bytes into one instruction word.
module word_packer
    import proc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [7:0]       i_byte,
    output logic [WIDTH-1:0] o_word,
    output logic             o_word_vld
);

    logic [1:0]  r_byte_cnt;
    logic [23:0] r_shift;

    // Bytes enter at the top so the first one ends up in bits [7:0].
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
        end else if (i_clear) begin
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
        end else if (i_valid) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {i_byte, r_shift[23:8]};
        end
    end

    assign o_word     = WIDTH'({i_byte, r_shift});
    assign o_word_vld = i_valid && (r_byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: fills instruction memory from a byte stream, then releases the core.
// Optional trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import proc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int IMEM_DEPTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ins_mem_en,
    output logic [WIDTH-1:0] ins_mem_addr,
    output logic [WIDTH-1:0] ins_mem_data,
    output logic             core_reset,
    output logic             busy,
    output logic             error
);

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(IMEM_DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t ST_AFTER_LOAD = ST_CSUM;
`else
    localparam loader_state_t ST_AFTER_LOAD = ST_RUN;
`endif

    loader_state_t    r_state;
    loader_state_t    w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_word_cnt;
    logic             r_mem_en;
    logic [WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0] r_mem_data;
    logic             r_core_reset;

    logic             w_accept;
    logic             w_sync;
    logic             w_data_byte;
    logic [LEN_W-1:0] w_len;
    logic             w_last_word;
    logic [WIDTH-1:0] w_word;
    logic             w_word_vld;

    assign in_ready    = (r_state != ST_ERR);
    assign w_accept    = in_valid && in_ready;
    assign w_sync      = w_accept && (in_data == SYNC_BYTE) &&
                         ((r_state == ST_IDLE) || (r_state == ST_RUN));
    assign w_data_byte = w_accept && (r_state == ST_DATA);
    assign w_len       = {in_data, r_len[7:0]};
    assign w_last_word = (r_word_cnt == (r_len - 1'b1));

    word_packer #(.WIDTH(WIDTH)) u_packer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_sync),
        .i_valid    (w_data_byte),
        .i_byte     (in_data),
        .o_word     (w_word),
        .o_word_vld (w_word_vld)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_csum <= 8'd0;
        else if (w_sync)
            r_csum <= 8'd0;
        else if (w_data_byte)
            r_csum <= r_csum + in_data;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_sync) w_state_nxt = ST_LEN0;
            ST_LEN0: if (w_accept) w_state_nxt = ST_LEN1;
            ST_LEN1: begin
                if (w_accept) begin
                    if (w_len == '0)
                        w_state_nxt = ST_AFTER_LOAD;
                    else if ({1'b0, w_len} > DEPTH_L)
                        w_state_nxt = ST_ERR;
                    else
                        w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: if (w_word_vld && w_last_word) w_state_nxt = ST_AFTER_LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: if (w_accept) w_state_nxt = (in_data == r_csum) ? ST_RUN : ST_ERR;
`endif
            ST_RUN:  if (w_sync) w_state_nxt = ST_LEN0;
            ST_ERR:  w_state_nxt = ST_ERR;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_word_cnt   <= '0;
            r_mem_en     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_core_reset <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_mem_en <= w_word_vld;
            if (w_accept && (r_state == ST_LEN0))
                r_len[7:0] <= in_data;
            if (w_accept && (r_state == ST_LEN1))
                r_len <= w_len;
            if (w_sync)
                r_word_cnt <= '0;
            else if (w_word_vld)
                r_word_cnt <= r_word_cnt + 1'b1;
            if (w_word_vld) begin
                r_mem_addr <= WIDTH'(r_word_cnt);
                r_mem_data <= w_word;
            end
            // Release lags RUN entry by a cycle (after the last write); reload re-asserts at once.
            r_core_reset <= !((r_state == ST_RUN) && (w_state_nxt == ST_RUN));
        end
    end

    assign ins_mem_en   = r_mem_en;
    assign ins_mem_addr = r_mem_addr;
    assign ins_mem_data = r_mem_data;
    assign core_reset   = r_core_reset;
    assign busy         = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                          (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign error        = (r_state == ST_ERR);

endmodule
